// File: rtl/seq_pkg.sv
// Shared note codes and transport states for the step sequencer
// and the downstream note decoder.
package seq_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        PLAY    = 2'd1,
        PAUSED  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/step_sequencer_if.sv
// Transport, tempo, pattern-edit and note output bundle
// for the step sequencer.
interface step_sequencer_if #(
    parameter int NUM_STEPS = 8,
    parameter int TICK_W    = 24
);
    localparam int IDX_W = $clog2(NUM_STEPS);

    logic              start;
    logic              pause;
    logic              stop;
    logic [TICK_W-1:0] step_len;
    logic [TICK_W-1:0] gate_len;
    logic [IDX_W:0]    seq_len;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [3:0]        wr_note;
    logic [3:0]        note_out;
    logic [IDX_W-1:0]  step_idx;
    logic              step_strobe;
    logic              playing;

    modport master (
        output start, pause, stop,
        output step_len, gate_len, seq_len,
        output wr_en, wr_addr, wr_note,
        input  note_out, step_idx, step_strobe, playing
    );

    modport slave (
        input  start, pause, stop,
        input  step_len, gate_len, seq_len,
        input  wr_en, wr_addr, wr_note,
        output note_out, step_idx, step_strobe, playing
    );

endinterface

// File: rtl/step_timer.sv
// Per-step tick counter with step-length clamp and the
// advance / gate-window comparisons.
module step_timer #(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clear,
    input  logic [TICK_W-1:0] step_len,
    input  logic [TICK_W-1:0] gate_len,
    output logic              advance,
    output logic              gate_open
);

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] last_tick;

    // Steps shorter than two cycles are stretched to two.
    assign last_tick = (step_len < TICK_W'(2))
                     ? TICK_W'(1)
                     : step_len - TICK_W'(1);

    // >= so that shrinking step_len mid-step advances promptly.
    assign advance   = run && (tick_cnt >= last_tick);
    assign gate_open = tick_cnt < gate_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= advance ? '0 : tick_cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Looping note-pattern sequencer with play/pause/stop transport,
// programmable tempo and gate, and a pattern edit port.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int TICK_W    = 24,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             rst,
    step_sequencer_if.slave  bus
);

    localparam logic [IDX_W:0] FULL_LEN = (IDX_W+1)'(NUM_STEPS);

    seq_state_t       state;
    logic [IDX_W-1:0] step_idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W:0]   eff_len;
    logic [3:0]       note_out;
    logic             step_strobe;
    logic [3:0]       pattern [NUM_STEPS];

    logic halt, hold, launch, resume;
    logic run, clear, wrap;
    logic advance, gate_open;

    // Transport priority: stop over pause over start.
    assign halt   = bus.stop;
    assign hold   = !halt && bus.pause;
    assign launch = !halt && !bus.pause && bus.start
                  && (state == STOPPED);
    assign resume = !halt && !bus.pause && bus.start
                  && (state == PAUSED);

    assign run   = (state == PLAY) && !halt && !bus.pause;
    assign clear = (state == STOPPED) || halt;

    step_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clear     (clear),
        .step_len  (bus.step_len),
        .gate_len  (bus.gate_len),
        .advance   (advance),
        .gate_open (gate_open)
    );

    assign eff_len = (bus.seq_len == '0 || bus.seq_len > FULL_LEN)
                   ? FULL_LEN
                   : bus.seq_len;

    // Also catches a loop shortened below the current step.
    assign wrap     = {1'b0, step_idx} >= (eff_len - 1'b1);
    assign next_idx = wrap ? '0 : step_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STOPPED;
            step_idx    <= '0;
            note_out    <= NOTE_REST;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= launch || advance;
            note_out    <= (state == PLAY && gate_open)
                         ? pattern[step_idx]
                         : NOTE_REST;
            if (halt) begin
                state    <= STOPPED;
                step_idx <= '0;
            end else if (hold && state == PLAY) begin
                state <= PAUSED;
            end else if (launch) begin
                state    <= PLAY;
                step_idx <= '0;
            end else if (resume) begin
                state <= PLAY;
            end else if (advance) begin
                step_idx <= next_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern[i] <= NOTE_REST;
            end
        end else if (bus.wr_en) begin
            pattern[bus.wr_addr] <= bus.wr_note;
        end
    end

    assign bus.note_out    = note_out;
    assign bus.step_idx    = step_idx;
    assign bus.step_strobe = step_strobe;
    assign bus.playing     = (state == PLAY);

endmodule

// File: tb/tb_step_sequencer.sv
// Scenario and randomized checks of step_sequencer against a
// cycle-level behavioural model of the transport and pattern.
module tb_step_sequencer;

    localparam int N  = 8;
    localparam int TW = 24;
    localparam int S_STOP  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_PAUSE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    int m_state, m_tick, m_idx, m_note, m_strobe;
    int m_pat [N];

    step_sequencer_if #(.NUM_STEPS(N), .TICK_W(TW)) bus ();

    step_sequencer #(.NUM_STEPS(N), .TICK_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dut_vec();
        return {bus.note_out, bus.step_idx,
                bus.step_strobe, bus.playing};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [3:0] n;
        logic [2:0] i;
        n = m_note[3:0];
        i = m_idx[2:0];
        return {n, i, m_strobe[0], m_state == S_PLAY};
    endfunction

    task automatic model_reset();
        m_state = S_STOP;
        m_tick = 0;
        m_idx = 0;
        m_note = 0;
        m_strobe = 0;
        for (int i = 0; i < N; i++) m_pat[i] = 0;
    endtask

    task automatic model_edge();
        int sl, el, nn, st;
        sl = (bus.step_len < 2) ? 2 : int'(bus.step_len);
        el = (bus.seq_len == 0 || bus.seq_len > N)
           ? N : int'(bus.seq_len);
        nn = (m_state == S_PLAY && m_tick < int'(bus.gate_len))
           ? m_pat[m_idx] : 0;
        st = 0;
        if (bus.stop) begin
            m_state = S_STOP;
            m_tick = 0;
            m_idx = 0;
        end else if (bus.pause) begin
            if (m_state == S_PLAY) m_state = S_PAUSE;
        end else if (bus.start && m_state == S_STOP) begin
            m_state = S_PLAY;
            m_tick = 0;
            m_idx = 0;
            st = 1;
        end else if (bus.start && m_state == S_PAUSE) begin
            m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            m_tick++;
            if (m_tick >= sl) begin
                m_tick = 0;
                m_idx = (m_idx + 1 >= el) ? 0 : m_idx + 1;
                st = 1;
            end
        end
        if (bus.wr_en) m_pat[bus.wr_addr] = int'(bus.wr_note);
        m_note = nn;
        m_strobe = st;
    endtask

    task automatic tick();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_vec() !== 9'd0) begin
            errors++;
            $display("FAIL reset got %h exp 000", dut_vec());
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h",
                     dut_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        int nz, strobes;
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_note = 4'(i + 1);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.step_len = 24'd10;
        bus.gate_len = 24'd6;
        bus.seq_len = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.step_strobe !== 1'b1 || bus.playing !== 1'b1) begin
            errors++;
            $display("FAIL start_strobe got %b%b exp 11",
                     bus.step_strobe, bus.playing);
        end
        nz = 0;
        strobes = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.note_out != 0) nz++;
            if (bus.step_strobe) strobes++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (nz != 48 || strobes != 8 || bus.step_idx !== 3'd0) begin
            errors++;
            $display("FAIL basic_totals got %0d/%0d/%0d exp 48/8/0",
                     nz, strobes, bus.step_idx);
        end
    endtask

    task automatic test_pause();
        int held, nz, guard;
        guard = 0;
        while (m_tick != 3 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL pause_wait got timeout exp tick 3");
        end
        bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0;
        held = m_idx;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || bus.note_out !== 4'd0
                || int'(bus.step_idx) != held) begin
                errors++;
                $display("FAIL paused cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.step_strobe !== 1'b0 || bus.playing !== 1'b1) begin
            errors++;
            $display("FAIL resume got %b%b exp 01",
                     bus.step_strobe, bus.playing);
        end
        nz = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.note_out != 0) nz++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL resume cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (nz != 3) begin
            errors++;
            $display("FAIL resume_gate got %0d exp 3", nz);
        end
    endtask

    task automatic test_seq_len();
        int guard, bad;
        bit wrapped;
        guard = 0;
        while (m_idx != 5 && guard < 200) begin
            tick();
            guard++;
        end
        bus.seq_len = 4'd3;
        wrapped = 0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.step_idx == 3'd0) wrapped = 1;
            else if (wrapped && bus.step_idx > 3'd2) bad++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL seqlen cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (guard >= 200 || !wrapped || bad != 0) begin
            errors++;
            $display("FAIL seqlen_loop got wrap %0d bad %0d exp 1 0",
                     wrapped, bad);
        end
        bus.seq_len = 4'd0;
    endtask

    task automatic test_edges();
        int nz, zs, strobes;
        bus.gate_len = 24'd0;
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.note_out != 0) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL gate0 got %0d notes exp 0", nz);
        end
        bus.gate_len = 24'd20;
        tick();
        zs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.note_out == 0) zs++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL legato cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (zs != 0) begin
            errors++;
            $display("FAIL legato_rest got %0d exp 0", zs);
        end
        bus.step_len = 24'd0;
        bus.gate_len = 24'd6;
        tick();
        tick();
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.step_strobe) strobes++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL step0 cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (strobes != 10) begin
            errors++;
            $display("FAIL step0_rate got %0d exp 10", strobes);
        end
        bus.step_len = 24'd10;
    endtask

    task automatic test_write_active();
        int guard;
        logic [3:0] nv;
        bus.gate_len = 24'd20;
        guard = 0;
        while (m_tick != 2 && guard < 40) begin
            tick();
            guard++;
        end
        nv = 4'(9 + (m_idx % 7));
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(m_idx);
        bus.wr_note = nv;
        tick();
        bus.wr_en = 1'b0;
        tick();
        checks++;
        if (bus.note_out !== nv || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL write_active got %h exp %h",
                     bus.note_out, nv);
        end
        bus.gate_len = 24'd6;
    endtask

    task automatic test_start_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.playing !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_stop cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0)
                bus.step_len = 24'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0)
                bus.gate_len = 24'($urandom_range(0, 8));
            if ($urandom_range(0, 29) == 0)
                bus.seq_len = 4'($urandom_range(0, 15));
            bus.start = ($urandom_range(0, 9) == 0);
            bus.pause = ($urandom_range(0, 24) == 0);
            bus.stop  = ($urandom_range(0, 49) == 0);
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_note = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int nz;
        bus.step_len = 24'd10;
        bus.gate_len = 24'd6;
        bus.seq_len = 4'd0;
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_note = 4'(i + 1);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (bus.playing !== 1'b1 || bus.note_out == 4'd0) begin
            errors++;
            $display("FAIL pre_reset got %h exp playing note",
                     dut_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 000", dut_vec());
        end
        tick();
        #3;
        rst = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nz = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.note_out != 0) nz++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %h exp %h",
                         i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL pattern_clear got %0d notes exp 0", nz);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.stop = 1'b0;
        bus.step_len = 24'd10;
        bus.gate_len = 24'd6;
        bus.seq_len = 4'd0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_note = 4'd0;
        model_reset();
        test_reset();
        test_basic();
        test_pause();
        test_seq_len();
        test_edges();
        test_write_active();
        test_start_stop();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Pattern sequencer that sits directly upstream of the note decoder and PWM generator.
- Stores a loop of 4-bit note codes and steps through them at a programmable tempo.
- Drives `note_out` with the current step's note during the gate window and REST (4'd0) for the remainder of the step.
- Provides play/pause/stop transport control and a write port for editing the pattern from button logic.

Parameters:
- NUM_STEPS, 8, number of pattern slots; power of two, 2..16.
- IDX_W, $clog2(NUM_STEPS), step index width.
- TICK_W, 24, width of the step/gate length counters. At 12 MHz this gives steps of up to 1.39 s.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: begin playback, or resume from pause.
- pause  in  1  single-cycle pulse: freeze playback in place.
- stop  in  1  single-cycle pulse: halt playback and rewind to step 0.
- step_len  in  TICK_W  clock cycles per step; sampled every cycle.
- gate_len  in  TICK_W  clock cycles the note sounds within each step.
- seq_len  in  IDX_W+1  active loop length, 1..NUM_STEPS; 0 means NUM_STEPS.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  IDX_W  step slot to write.
- wr_note  in  4  note code to store.
- note_out  out  4  note code for the downstream decoder; 0 = REST.
- step_idx  out  IDX_W  current step (drives LEDs).
- step_strobe  out  1  one-cycle pulse on each step advance and on playback start.
- playing  out  1  high in PLAY state only.

Behaviour:
- Reset (async, rst=1):
  - state=STOPPED, step_idx=0, tick_cnt=0.
  - note_out=0, step_strobe=0, playing=0.
  - All pattern slots cleared to 0.
- States and transitions:
  - STOPPED: `start` → PLAY, with tick_cnt=0 and step_idx=0; step_strobe pulses on the transition cycle.
  - PLAY: `pause` → PAUSED; `stop` → STOPPED.
  - PAUSED: `start` → PLAY, resuming at the held tick_cnt and step_idx; step_strobe does not pulse. `stop` → STOPPED.
  - Priority when inputs coincide: stop > pause > start.
  - `start` in PLAY and `pause` outside PLAY are ignored.
- Entering STOPPED: tick_cnt=0, step_idx=0.
- PLAY timing:
  - tick_cnt increments each cycle.
  - When tick_cnt == step_len-1: tick_cnt←0 and step_idx advances; step_strobe=1 on that same cycle (registered).
  - Wrap: if step_idx >= eff_len-1, the next step_idx is 0. eff_len = (seq_len==0 || seq_len>NUM_STEPS) ? NUM_STEPS : seq_len.
  - If seq_len shrinks below the current step_idx, playback wraps to 0 at the next advance and never indexes a slot outside the loop.
  - step_len==0 or 1: treated as 2 (minimum step = 2 cycles).
- Gate:
  - Let gated = (state==PLAY) && (tick_cnt < gate_len).
  - note_out is a register: note_out ← gated ? pattern[step_idx] : 0.
  - This gives one cycle of latency relative to step_idx/tick_cnt.
  - gate_len==0: always REST.
  - gate_len >= step_len: legato; the note never drops between steps.
  - In PAUSED and STOPPED, note_out=0 from the next cycle.
- Pattern writes:
  - Write takes effect at the clock edge when wr_en=1, in any state.
  - A write to the currently playing slot appears on note_out one cycle later.
  - Codes 9..15 are stored unchanged; the downstream decoder owns their interpretation.
- Widths:
  - tick_cnt is TICK_W wide and compares against step_len-1 and gate_len unsigned; no overflow is possible.
  - step_idx is IDX_W wide.
- Length changes mid-step: step_len or gate_len changing mid-step takes effect immediately. If step_len drops to ≤ tick_cnt, the step advances on the next cycle: the comparison is tick_cnt >= step_len-1, not equality.

Decomposition:
- seq_pkg holds:
  - Note localparams NOTE_REST..NOTE_C5 (0..8), shared with the note decoder.
  - typedef enum logic [1:0] {STOPPED, PLAY, PAUSED} seq_state_t.
- One sub-module, step_timer:
  - Contains tick_cnt, the step_len clamp, and the advance/gate compare.
  - Inputs: run, clear.
  - Outputs: advance, gate_open.
- Pattern storage and the FSM stay in step_sequencer.

Test Plan:
- Reset, then write slots 0..7 = 1..8; step_len=10, gate_len=6, seq_len=0; pulse start:
  - step_strobe every 10 cycles.
  - note_out = 1 for 6 cycles, then 0 for 4 cycles, then 2, and so on.
  - After slot 7, step_idx wraps to 0.
- Pause mid-step at tick_cnt=3, wait 50 cycles, then start:
  - note_out=0 and step_idx held while paused.
  - After resume, note_out resumes with 3 cycles of gate remaining.
  - No step_strobe on resume.
- seq_len=3 while at step 5 → the next advance goes to step 0; steps then loop 0,1,2.
- Edge settings:
  - gate_len=0 → note_out stays 0.
  - gate_len=20 with step_len=10 → note_out changes directly between notes with no 0 cycles.
  - step_len=0 → advance every 2 cycles.
- Simultaneous start+stop in STOPPED → stays STOPPED.
- Write to the active slot during PLAY → new code on note_out within 1 cycle.
- Assert rst mid-PLAY (async, between edges) → all outputs 0 immediately and the pattern is cleared.
